// File: rtl/tiny_cpu.sv
// tiny_cpu: 16-bit, four-register datapath with ALU, shifter and flags.
// Register reads and every output are combinational; the register file
// is the only state and updates on the rising clock edge.
module tiny_cpu (
   input  logic        clk,
   input  logic        reset,
   input  logic        LoadEnable,
   input  logic [1:0]  ASelect,
   input  logic [1:0]  BSelect,
   input  logic [1:0]  DestinationSelect,
   input  logic [15:0] ConstantIn,
   input  logic        MBSelect,
   input  logic        MDSelect,
   input  logic [3:0]  GSelect,
   input  logic [1:0]  HSelect,
   input  logic        MFSelect,
   input  logic [15:0] DataIn,
   output logic [15:0] AddressOut,
   output logic [15:0] DataOut,
   output logic        statC,
   output logic        statV,
   output logic        statN,
   output logic        statZ
);

   logic [15:0] regFile_r [4];

   logic [15:0] aBus_s;
   logic [15:0] bOperand_s;
   logic [15:0] addB_s;
   logic        carryIn_s;
   logic        arithFlags_s;
   logic [16:0] sum_s;
   logic [15:0] logicResult_s;
   logic [15:0] aluResult_s;
   logic [15:0] shiftResult_s;
   logic [15:0] fResult_s;
   logic [15:0] writeData_s;

   // Operand buses: A is always a register, B may be replaced by the constant.
   always_comb begin
      aBus_s = regFile_r[ASelect];
      if (MBSelect == 1'b1) begin
         bOperand_s = ConstantIn;
      end else begin
         bOperand_s = regFile_r[BSelect];
      end
   end

   // Pick the adder's second operand and carry-in; only true adder ops
   // may raise carry/overflow.
   always_comb begin
      addB_s       = 16'h0000;
      carryIn_s    = 1'b0;
      arithFlags_s = 1'b0;
      if (GSelect[3] == 1'b0) begin
         case (GSelect[2:0])
            3'b000: begin addB_s = 16'h0000;    carryIn_s = 1'b0; arithFlags_s = 1'b0; end
            3'b001: begin addB_s = 16'h0000;    carryIn_s = 1'b1; arithFlags_s = 1'b1; end
            3'b010: begin addB_s = bOperand_s;  carryIn_s = 1'b0; arithFlags_s = 1'b1; end
            3'b011: begin addB_s = bOperand_s;  carryIn_s = 1'b1; arithFlags_s = 1'b1; end
            3'b100: begin addB_s = ~bOperand_s; carryIn_s = 1'b0; arithFlags_s = 1'b1; end
            3'b101: begin addB_s = ~bOperand_s; carryIn_s = 1'b1; arithFlags_s = 1'b1; end
            3'b110: begin addB_s = 16'hFFFF;    carryIn_s = 1'b0; arithFlags_s = 1'b1; end
            3'b111: begin addB_s = 16'h0000;    carryIn_s = 1'b0; arithFlags_s = 1'b0; end
            default: begin addB_s = 16'h0000;   carryIn_s = 1'b0; arithFlags_s = 1'b0; end
         endcase
      end else begin
         addB_s       = 16'h0000;
         carryIn_s    = 1'b0;
         arithFlags_s = 1'b0;
      end
   end

   assign sum_s = {1'b0, aBus_s} + {1'b0, addB_s} + {16'h0000, carryIn_s};

   // Bitwise logic unit; GSelect[2] is a don't-care for these ops.
   always_comb begin
      logicResult_s = 16'h0000;
      case (GSelect[1:0])
         2'b00:   logicResult_s = aBus_s & bOperand_s;
         2'b01:   logicResult_s = aBus_s | bOperand_s;
         2'b10:   logicResult_s = aBus_s ^ bOperand_s;
         2'b11:   logicResult_s = ~aBus_s;
         default: logicResult_s = 16'h0000;
      endcase
   end

   // ALU result: adder for arithmetic ops, logic unit otherwise.
   always_comb begin
      if (GSelect[3] == 1'b1) begin
         aluResult_s = logicResult_s;
      end else begin
         aluResult_s = sum_s[15:0];
      end
   end

   // Single-bit shifter acting on the B operand.
   always_comb begin
      shiftResult_s = bOperand_s;
      case (HSelect)
         2'b00:   shiftResult_s = bOperand_s;
         2'b01:   shiftResult_s = {1'b0, bOperand_s[15:1]};
         2'b10:   shiftResult_s = {bOperand_s[14:0], 1'b0};
         2'b11:   shiftResult_s = bOperand_s;
         default: shiftResult_s = bOperand_s;
      endcase
   end

   // Function-unit select and register write-data select.
   always_comb begin
      if (MFSelect == 1'b1) begin
         fResult_s = shiftResult_s;
      end else begin
         fResult_s = aluResult_s;
      end
      if (MDSelect == 1'b1) begin
         writeData_s = DataIn;
      end else begin
         writeData_s = fResult_s;
      end
   end

   // Register file: reset clears everything and overrides any pending write.
   always_ff @(posedge clk) begin
      if (reset == 1'b1) begin
         for (int i = 0; i < 4; i++) begin
            regFile_r[i] <= 16'h0000;
         end
      end else if (LoadEnable == 1'b1) begin
         regFile_r[DestinationSelect] <= writeData_s;
      end else begin
         for (int i = 0; i < 4; i++) begin
            regFile_r[i] <= regFile_r[i];
         end
      end
   end

   // Flags always reflect the ALU path, whatever MFSelect chooses.
   always_comb begin
      statC = arithFlags_s & sum_s[16];
      statV = arithFlags_s & (aBus_s[15] == addB_s[15]) & (sum_s[15] != aBus_s[15]);
      statN = aluResult_s[15];
      statZ = (aluResult_s == 16'h0000);
   end

   assign AddressOut = aBus_s;
   assign DataOut    = bOperand_s;

endmodule

// File: tb/tb_tiny_cpu.sv
// Testbench for tiny_cpu: directed vector table, reset/hold sequences and
// randomized cycles checked against an arithmetic reference model.
module tb_tiny_cpu;

   logic        clk;
   logic        reset;
   logic        LoadEnable;
   logic [1:0]  ASelect;
   logic [1:0]  BSelect;
   logic [1:0]  DestinationSelect;
   logic [15:0] ConstantIn;
   logic        MBSelect;
   logic        MDSelect;
   logic [3:0]  GSelect;
   logic [1:0]  HSelect;
   logic        MFSelect;
   logic [15:0] DataIn;
   logic [15:0] AddressOut;
   logic [15:0] DataOut;
   logic        statC;
   logic        statV;
   logic        statN;
   logic        statZ;

   int checks = 0;
   int errors = 0;
   int mdl [4];

   tiny_cpu dut (
      .clk(clk), .reset(reset), .LoadEnable(LoadEnable),
      .ASelect(ASelect), .BSelect(BSelect), .DestinationSelect(DestinationSelect),
      .ConstantIn(ConstantIn), .MBSelect(MBSelect), .MDSelect(MDSelect),
      .GSelect(GSelect), .HSelect(HSelect), .MFSelect(MFSelect), .DataIn(DataIn),
      .AddressOut(AddressOut), .DataOut(DataOut),
      .statC(statC), .statV(statV), .statN(statN), .statZ(statZ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          le, md, mb, mf;
      logic [1:0]  a, b, d, h;
      logic [3:0]  g;
      logic [15:0] k, din;
      logic [15:0] expAddr, expData;
      logic [3:0]  expFlags; // {C,V,N,Z}
   } vec_t;

   vec_t vec [18];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
      end
   endtask

   // Reference ALU from signed/unsigned arithmetic meaning of each op.
   function automatic void refAlu(input int ua, input int ub, input logic [3:0] g,
                                  output int res, output bit c, output bit v);
      int sa, sb, m, s;
      bit arith;
      sa = (ua >= 32768) ? ua - 65536 : ua;
      sb = (ub >= 32768) ? ub - 65536 : ub;
      m = ua; s = sa; c = 1'b0; arith = 1'b0;
      if (g[3]) begin
         case (g[1:0])
            2'd0: m = ua & ub;
            2'd1: m = ua | ub;
            2'd2: m = ua ^ ub;
            default: m = 65535 - ua;
         endcase
      end else begin
         case (g[2:0])
            3'd1: begin m = ua + 1;      s = sa + 1;      c = (ua == 65535); arith = 1'b1; end
            3'd2: begin m = ua + ub;     s = sa + sb;     c = (m > 65535);   arith = 1'b1; end
            3'd3: begin m = ua + ub + 1; s = sa + sb + 1; c = (m > 65535);   arith = 1'b1; end
            3'd4: begin m = ua - ub - 1; s = sa - sb - 1; c = (ua > ub);     arith = 1'b1; end
            3'd5: begin m = ua - ub;     s = sa - sb;     c = (ua >= ub);    arith = 1'b1; end
            3'd6: begin m = ua - 1;      s = sa - 1;      c = (ua != 0);     arith = 1'b1; end
            default: m = ua;
         endcase
      end
      res = m & 32'h0000FFFF;
      v = arith && ((s > 32767) || (s < -32768));
   endfunction

   function automatic int refShift(input int ub, input logic [1:0] h);
      if (h == 2'd1) return ub / 2;
      else if (h == 2'd2) return (ub * 2) % 65536;
      else return ub;
   endfunction

   // Model's view of the write that the coming edge performs.
   task automatic modelEdge();
      int bop, res, f;
      bit c, v;
      bop = MBSelect ? int'(ConstantIn) : mdl[BSelect];
      refAlu(mdl[ASelect], bop, GSelect, res, c, v);
      f = MFSelect ? refShift(bop, HSelect) : res;
      if (reset) begin
         for (int i = 0; i < 4; i++) mdl[i] = 0;
      end else if (LoadEnable) begin
         mdl[DestinationSelect] = MDSelect ? int'(DataIn) : f;
      end
   endtask

   task automatic tick();
      modelEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      reset = 1'b0; LoadEnable = 1'b0; ASelect = 2'd0; BSelect = 2'd0;
      DestinationSelect = 2'd0; ConstantIn = 16'd0; MBSelect = 1'b0; MDSelect = 1'b0;
      GSelect = 4'd0; HSelect = 2'd0; MFSelect = 1'b0; DataIn = 16'd0;
   endtask

   initial begin
      int res, bop;
      bit c, v;
      logic [15:0] saved [4];

      // Table of directed vectors: {le,md,mb,mf,a,b,d,h,g,k,din, expAddr,expData,expFlags}
      vec[0]  = '{0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 4'b0000, 16'd0,     16'd0,     16'd0,     16'd0,     4'b0001};
      vec[1]  = '{1,1,0,0, 2'd0,2'd0,2'd0,2'd0, 4'b0000, 16'd0,     16'd12345, 16'd0,     16'd0,     4'b0001};
      vec[2]  = '{1,1,0,0, 2'd0,2'd0,2'd1,2'd0, 4'b0000, 16'd0,     16'd22222, 16'd12345, 16'd12345, 4'b0000};
      vec[3]  = '{1,0,0,0, 2'd0,2'd1,2'd3,2'd0, 4'b0010, 16'd0,     16'd0,     16'd12345, 16'd22222, 4'b0110};
      vec[4]  = '{0,0,0,0, 2'd0,2'd3,2'd0,2'd0, 4'b0000, 16'd0,     16'd0,     16'd12345, 16'd34567, 4'b0000};
      vec[5]  = '{1,1,0,0, 2'd0,2'd0,2'd0,2'd0, 4'b0000, 16'd0,     16'd5,     16'd12345, 16'd12345, 4'b0000};
      vec[6]  = '{0,0,1,0, 2'd0,2'd0,2'd0,2'd0, 4'b0101, 16'd5,     16'd0,     16'd5,     16'd5,     4'b1001};
      vec[7]  = '{0,0,1,0, 2'd0,2'd0,2'd0,2'd0, 4'b0101, 16'd6,     16'd0,     16'd5,     16'd6,     4'b0010};
      vec[8]  = '{1,1,1,0, 2'd0,2'd0,2'd0,2'd0, 4'b0101, 16'd6,     16'hFFFF,  16'd5,     16'd6,     4'b0010};
      vec[9]  = '{0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 4'b0001, 16'd0,     16'd0,     16'hFFFF,  16'hFFFF,  4'b1001};
      vec[10] = '{1,1,0,0, 2'd0,2'd0,2'd0,2'd0, 4'b0001, 16'd0,     16'h8000,  16'hFFFF,  16'hFFFF,  4'b1001};
      vec[11] = '{0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 4'b0110, 16'd0,     16'd0,     16'h8000,  16'h8000,  4'b1100};
      vec[12] = '{1,0,1,1, 2'd0,2'd0,2'd2,2'd1, 4'b0110, 16'h8001,  16'd0,     16'h8000,  16'h8001,  4'b1100};
      vec[13] = '{0,0,0,0, 2'd0,2'd2,2'd0,2'd0, 4'b0000, 16'd0,     16'd0,     16'h8000,  16'h4000,  4'b0010};
      vec[14] = '{1,0,1,1, 2'd0,2'd2,2'd2,2'd2, 4'b0000, 16'h8001,  16'd0,     16'h8000,  16'h8001,  4'b0010};
      vec[15] = '{0,0,0,0, 2'd0,2'd2,2'd0,2'd0, 4'b0000, 16'd0,     16'd0,     16'h8000,  16'h0002,  4'b0010};
      vec[16] = '{1,0,1,1, 2'd0,2'd2,2'd2,2'd0, 4'b0000, 16'h8001,  16'd0,     16'h8000,  16'h8001,  4'b0010};
      vec[17] = '{0,0,0,0, 2'd0,2'd2,2'd0,2'd0, 4'b0000, 16'd0,     16'd0,     16'h8000,  16'h8001,  4'b0010};

      idleInputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;

      // Directed table
      for (int i = 0; i < 18; i++) begin
         LoadEnable = vec[i].le; MDSelect = vec[i].md; MBSelect = vec[i].mb; MFSelect = vec[i].mf;
         ASelect = vec[i].a; BSelect = vec[i].b; DestinationSelect = vec[i].d; HSelect = vec[i].h;
         GSelect = vec[i].g; ConstantIn = vec[i].k; DataIn = vec[i].din;
         #2;
         chk("vec_addr", i, {16'd0, AddressOut}, {16'd0, vec[i].expAddr});
         chk("vec_data", i, {16'd0, DataOut}, {16'd0, vec[i].expData});
         chk("vec_flags", i, {28'd0, statC, statV, statN, statZ}, {28'd0, vec[i].expFlags});
         tick();
      end

      // Reset has priority over a simultaneous write
      idleInputs();
      reset = 1'b1; LoadEnable = 1'b1; MDSelect = 1'b1; DataIn = 16'h1234; DestinationSelect = 2'd1;
      tick();
      idleInputs();
      for (int i = 0; i < 4; i++) begin
         ASelect = 2'(i); BSelect = 2'(i);
         #1;
         chk("rst_addr", i, {16'd0, AddressOut}, 32'd0);
         chk("rst_data", i, {16'd0, DataOut}, 32'd0);
      end
      ASelect = 2'd0; BSelect = 2'd0;
      #1;
      chk("rst_flags", 0, {28'd0, statC, statV, statN, statZ}, 32'h1);

      // Load nonzero values, then hold for 10 edges with LoadEnable low
      for (int i = 0; i < 4; i++) begin
         saved[i] = 16'($urandom_range(1, 65535));
         idleInputs();
         LoadEnable = 1'b1; MDSelect = 1'b1; DestinationSelect = 2'(i); DataIn = saved[i];
         tick();
      end
      for (int n = 0; n < 10; n++) begin
         idleInputs();
         DataIn = 16'($urandom); DestinationSelect = 2'($urandom); GSelect = 4'($urandom);
         MDSelect = 1'($urandom);
         tick();
      end
      idleInputs();
      for (int i = 0; i < 4; i++) begin
         ASelect = 2'(i); BSelect = 2'(3 - i);
         #1;
         chk("hold_addr", i, {16'd0, AddressOut}, {16'd0, saved[i]});
         chk("hold_data", i, {16'd0, DataOut}, {16'd0, saved[3 - i]});
      end

      // Randomized cycles against the reference model
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 29) == 0);
         LoadEnable = 1'($urandom); MDSelect = 1'($urandom); MBSelect = 1'($urandom);
         MFSelect = 1'($urandom); ASelect = 2'($urandom); BSelect = 2'($urandom);
         DestinationSelect = 2'($urandom); HSelect = 2'($urandom); GSelect = 4'($urandom);
         ConstantIn = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         DataIn = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
         #2;
         bop = MBSelect ? int'(ConstantIn) : mdl[BSelect];
         refAlu(mdl[ASelect], bop, GSelect, res, c, v);
         chk("rand_addr", n, {16'd0, AddressOut}, 32'(mdl[ASelect]));
         chk("rand_data", n, {16'd0, DataOut}, 32'(bop));
         chk("rand_flags", n, {28'd0, statC, statV, statN, statZ},
             {28'd0, c, v, (res >= 32768), (res == 0)});
         tick();
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tiny_cpu.md
TINY_CPU -- requirements
Module: tiny_cpu

Interface
REQ-001 Parameters: none; datapath fixed at 16 bits, 4 registers R0-R3.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; clears register file.
REQ-004 LoadEnable  in  1  write enable for register file.
REQ-005 ASelect  in  2  register driving A bus.
REQ-006 BSelect  in  2  register driving B bus.
REQ-007 DestinationSelect  in  2  register written when LoadEnable=1.
REQ-008 ConstantIn  in  16  constant operand.
REQ-009 MBSelect  in  1  0: B operand = R[BSelect]; 1: B operand = ConstantIn.
REQ-010 MDSelect  in  1  0: write data = function-unit result; 1: write data = DataIn.
REQ-011 GSelect  in  4  ALU operation.
REQ-012 HSelect  in  2  shifter operation.
REQ-013 MFSelect  in  1  0: function result = ALU; 1: function result = shifter.
REQ-014 DataIn  in  16  external memory read data.
REQ-015 AddressOut  out  16  A bus (R[ASelect]), combinational.
REQ-016 DataOut  out  16  B operand after MBSelect mux, combinational.
REQ-017 statC, statV, statN, statZ  out  1 each  ALU carry, overflow, negative, zero; combinational.

Function
REQ-018 Register reads: combinational and asynchronous to clk; a same-cycle write becomes visible only after the rising edge.
REQ-019 Write: on rising edge with reset=0 and LoadEnable=1, R[DestinationSelect] <= (MDSelect ? DataIn : F). With LoadEnable=0 all registers hold.
REQ-020 ALU, A = R[ASelect], B = B operand, 17-bit internal sum, result modulo 2^16. GSelect 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+1; 0100 A+~B; 0101 A+~B+1 (A-B); 0110 A-1 (A+FFFF); 0111 A.
REQ-021 ALU logic ops, GSelect[3]=1 (GSelect[2] ignored): x00 A&B; x01 A|B; x10 A^B; x11 ~A.
REQ-022 Shifter on B operand: HSelect 00 B; 01 logical right shift 1 (MSB<=0); 10 logical left shift 1 (LSB<=0); 11 B.
REQ-023 F = MFSelect ? shifter : ALU.
REQ-024 Flags always from the ALU result, independent of MFSelect. statC = bit 16 of the sum. statV = 1 when both adder operands share a sign that differs from the result sign. statN = result[15]. statZ = (result==0).
REQ-025 For logic ops and pass-A ops (0000, 0111), statC=0 and statV=0.
REQ-026 Destination equal to a source register: the read returns the old value; the new value is written at the edge.
REQ-027 All outputs are purely combinational from register contents and inputs; no output registers, no pipeline.

Reset
REQ-028 On a rising edge with reset=1, R0-R3 <= 0; reset has priority over LoadEnable.
REQ-029 After reset with ASelect=BSelect=0, MBSelect=0, GSelect=0000: AddressOut=0, DataOut=0, statZ=1, statC=statV=statN=0.
REQ-030 Reset may be asserted at any cycle; any in-progress write in that cycle is discarded.

Verification
REQ-031 Load: MDSelect=1, LoadEnable=1. Dest=0 with DataIn=12345, one edge. Then Dest=1 with DataIn=22222, one edge. Result: R0=12345, R1=22222, read back via BSelect on DataOut.
REQ-032 Add: ASelect=0, BSelect=1, GSelect=0010, MDSelect=0, MFSelect=0, Dest=3, LoadEnable=1, one edge. Result: R3=34567, statN=1, statV=1, statC=0, statZ=0. BSelect=3 gives DataOut=34567.
REQ-033 Subtract/borrow: R0=5, MBSelect=1, ConstantIn=5, GSelect=0101. Result: ALU=0, statZ=1, statC=1. Then ConstantIn=6: ALU=FFFF, statN=1, statC=0.
REQ-034 Wrap: R0=FFFF, GSelect=0001. Result: ALU=0000, statC=1, statZ=1. R0=8000 with GSelect=0110: result 7FFF, statV=1.
REQ-035 Shifter: MBSelect=1, ConstantIn=8001, MFSelect=1. HSelect=01 writes 4000; HSelect=10 writes 0002; HSelect=00 writes 8001.
REQ-036 Reset/hold: registers loaded with nonzero values, reset=1 with LoadEnable=1 for one edge gives all registers 0. With LoadEnable=0, registers are unchanged across 10 edges.
